// File: rtl/fpu_issue_ctrl_if.sv
// Request/response handshake bundle between front end and FPU issue controller.
// master: front end (drives requests, consumes responses); slave: controller.
interface fpu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_z;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_err
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: one request at a time, run/stall to add/mul/div units,
// registered response with watchdog abort. Ports: clk, rst_n, bus (slave side
// of fpu_issue_ctrl_if), shared operands unit_x/unit_y, add_op, per-unit
// run/stall/z. Optional FPU_ISSUE_PERF_EN adds perf_clr, perf_busy, perf_ops.
module fpu_issue_ctrl #(
  parameter int MAX_WAIT = 40,
  parameter int CNT_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  fpu_issue_ctrl_if.slave   bus,
  output logic [31:0]       unit_x,
  output logic [31:0]       unit_y,
  output logic [1:0]        add_op,
  output logic              add_run,
  output logic              mul_run,
  output logic              div_run,
  input  logic              add_stall,
  input  logic              mul_stall,
  input  logic              div_stall,
  input  logic [31:0]       add_z,
  input  logic [31:0]       mul_z,
  input  logic [31:0]       div_z
`ifdef FPU_ISSUE_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_busy,
  output logic [15:0]       perf_ops
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [31:0]        x_q, y_q;
  logic [1:0]         add_op_q;
  logic               add_run_q, mul_run_q, div_run_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_z_q;
  logic               rsp_err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               is_mul, is_div;
  logic               stall_sel;
  logic [31:0]        z_sel;

  assign is_mul = (op_q == 3'd4);
  assign is_div = (op_q == 3'd5);

  always_comb begin
    stall_sel = add_stall;
    z_sel     = add_z;
    unique case (1'b1)
      is_mul: begin
        stall_sel = mul_stall;
        z_sel     = mul_z;
      end
      is_div: begin
        stall_sel = div_stall;
        z_sel     = div_z;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      add_op_q    <= '0;
      add_run_q   <= 1'b0;
      mul_run_q   <= 1'b0;
      div_run_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            x_q         <= bus.req_x;
            y_q         <= bus.req_y;
            add_op_q    <= bus.req_op[1:0];
            req_ready_q <= 1'b0;
            if (bus.req_op[2:1] == 2'b11) begin
              // Illegal op: answer at once, no unit touched.
              rsp_z_q     <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              add_run_q <= ~bus.req_op[2];
              mul_run_q <= (bus.req_op == 3'd4);
              div_run_q <= (bus.req_op == 3'd5);
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          if (!stall_sel) begin
            rsp_z_q     <= z_sel;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            add_run_q   <= 1'b0;
            mul_run_q   <= 1'b0;
            div_run_q   <= 1'b0;
            state_q     <= HOLD;
          end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            // This is the MAX_WAIT-th stalled run cycle: abort.
            rsp_z_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            add_run_q   <= 1'b0;
            mul_run_q   <= 1'b0;
            div_run_q   <= 1'b0;
            state_q     <= HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          // Run is already low here, giving units a clear cycle.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_err   = rsp_err_q;
  assign unit_x        = x_q;
  assign unit_y        = y_q;
  assign add_op        = add_op_q;
  assign add_run       = add_run_q;
  assign mul_run       = mul_run_q;
  assign div_run       = div_run_q;

`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] busy_q;
  logic [15:0] ops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      ops_q  <= '0;
    end else if (perf_clr) begin
      busy_q <= '0;
      ops_q  <= '0;
    end else begin
      if (state_q == RUN && busy_q != '1)
        busy_q <= busy_q + 1'b1;
      if (state_q == HOLD && bus.rsp_ready && !rsp_err_q && ops_q != '1)
        ops_q <= ops_q + 1'b1;
    end
  end

  assign perf_busy = busy_q;
  assign perf_ops  = ops_q;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with stub units of fixed latency.
// Stubs stall for (len-1) run cycles and present their result when stall drops.
module tb_fpu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] unit_x, unit_y;
  logic [1:0]  add_op;
  logic        add_run, mul_run, div_run;
  logic        add_stall, mul_stall, div_stall;
  logic [31:0] add_z, mul_z, div_z;
`ifdef FPU_ISSUE_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_busy;
  logic [15:0] perf_ops;
`endif

  fpu_issue_ctrl_if bus ();

  fpu_issue_ctrl #(.MAX_WAIT(40), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .unit_x    (unit_x),
    .unit_y    (unit_y),
    .add_op    (add_op),
    .add_run   (add_run),
    .mul_run   (mul_run),
    .div_run   (div_run),
    .add_stall (add_stall),
    .mul_stall (mul_stall),
    .div_stall (div_stall),
    .add_z     (add_z),
    .mul_z     (mul_z),
    .div_z     (div_z)
`ifdef FPU_ISSUE_PERF_EN
    ,
    .perf_clr  (perf_clr),
    .perf_busy (perf_busy),
    .perf_ops  (perf_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          add_len = 4, mul_len = 26, div_len = 27;
  int          add_c = 0, mul_c = 0, div_c = 0;
  logic [31:0] add_res = '0, mul_res = '0, div_res = '0;

  always @(posedge clk) begin
    add_c <= add_run ? add_c + 1 : 0;
    mul_c <= mul_run ? mul_c + 1 : 0;
    div_c <= div_run ? div_c + 1 : 0;
  end

  assign add_stall = add_run && (add_c < add_len - 1);
  assign mul_stall = mul_run && (mul_c < mul_len - 1);
  assign div_stall = div_run && (div_c < div_len - 1);
  assign add_z = add_stall ? 32'hDEADBEEF : add_res;
  assign mul_z = mul_stall ? 32'hDEADBEEF : mul_res;
  assign div_z = div_stall ? 32'hDEADBEEF : div_res;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Issue one request and wait for its response; response left pending.
  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [31:0] x, input logic [31:0] y,
                       input int exp_lat, input int exp_runs,
                       input logic [31:0] exp_z, input logic exp_err);
    int lat, runs, wrong, rdyc, xbad;
    logic sel;
    chk({tag, ".idle_rdy"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".gap"}, 32'(add_run | mul_run | div_run), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1; runs = 0; wrong = 0; rdyc = 0; xbad = 0;
    while (!bus.rsp_valid && lat < 200) begin
      sel = (op == 3'd4) ? mul_run : (op == 3'd5) ? div_run : add_run;
      if (sel) runs++;
      if (op == 3'd4) wrong += int'(add_run) + int'(div_run);
      else if (op == 3'd5) wrong += int'(add_run) + int'(mul_run);
      else wrong += int'(mul_run) + int'(div_run);
      if (sel && (unit_x !== x || unit_y !== y || add_op !== op[1:0])) xbad++;
      if (bus.req_ready) rdyc++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".runs"}, 32'(runs), 32'(exp_runs));
    chk({tag, ".z"}, bus.rsp_z, exp_z);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
    if (wrong != 0) chk({tag, ".wrong_unit"}, 32'(wrong), 32'd0);
    if (xbad != 0) chk({tag, ".operands"}, 32'(xbad), 32'd0);
    if (rdyc != 0) chk({tag, ".busy_rdy"}, 32'(rdyc), 32'd0);
    chk({tag, ".run_off"}, 32'(add_run | mul_run | div_run), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;
`ifdef FPU_ISSUE_PERF_EN
    perf_clr      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst.rsp_z", bus.rsp_z, 32'd0);
    chk("rst.runs", 32'({add_run, mul_run, div_run}), 32'd0);
    chk("rst.unit_x", unit_x, 32'd0);
    chk("rst.add_op", 32'(add_op), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    add_res = 32'h40400000;
    do_op("fad", 3'd0, 32'h3F800000, 32'h40000000, 5, 4, 32'h40400000, 1'b0);
    @(posedge clk);
    #1;
`ifdef FPU_ISSUE_PERF_EN
    chk("perf.busy", perf_busy, 32'd4);
    chk("perf.ops", 32'(perf_ops), 32'd1);
`endif

    mul_res = 32'h40C00000;
    do_op("fml1", 3'd4, 32'h40000000, 32'h40400000, 27, 26, 32'h40C00000, 1'b0);
    @(posedge clk);
    #1;
    do_op("fml2", 3'd4, 32'h40000000, 32'h40400000, 27, 26, 32'h40C00000, 1'b0);
    @(posedge clk);
    #1;

    div_res = 32'h7F800000;
    do_op("fdv", 3'd5, 32'h3F800000, 32'h00000000, 28, 27, 32'h7F800000, 1'b0);
    @(posedge clk);
    #1;

    add_res = 32'h00000003;
    do_op("flr", 3'd1, 32'h40490FDB, 32'h00000000, 5, 4, 32'h00000003, 1'b0);
    @(posedge clk);
    #1;

    bus.rsp_ready = 1'b0;
    do_op("ill", 3'd6, 32'h12345678, 32'h9ABCDEF0, 1, 0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("ill.hold_v", 32'({bus.rsp_valid, bus.rsp_err, bus.req_ready}),
          32'b110);
      chk("ill.hold_z", bus.rsp_z, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ill.release", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);

    add_len = 1000;
    do_op("wdog", 3'd0, 32'h3F800000, 32'h40000000, 41, 40, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("wdog.idle", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);
    add_len = 4;
    @(posedge clk);
    #1;

    bus.req_valid = 1'b1;
    bus.req_op    = 3'd4;
    bus.req_x     = 32'h40000000;
    bus.req_y     = 32'h40400000;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rstmid.running", 32'(mul_run), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.mul_run", 32'(mul_run), 32'd0);
    chk("rstmid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstmid.req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    add_res = 32'h40400000;
    do_op("fad2", 3'd0, 32'h3F800000, 32'h40000000, 5, 4, 32'h40400000, 1'b0);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator side of the FPU run/stall protocol.
- Accepts one floating-point request at a time over a valid/ready interface and registers its operands.
- Drives run to the adder, multiplier or divider, and holds run high while that unit asserts stall.
- Captures the result when stall drops and returns it over a valid/ready response interface. Sits between the CPU/coprocessor front end and the three FPU units.

Parameters:
- MAX_WAIT, 40, watchdog limit in run cycles; exceeding it aborts the operation with an error.
- CNT_W, 6, width of the run-cycle counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  3  0 FAD, 1 FLR, 2 FLT, 3 FSB, 4 FML, 5 FDV, 6/7 illegal
- req_x, req_y  in  32  operands
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_z  out  32  result
- rsp_err  out  1  illegal op or watchdog abort
- unit_x, unit_y  out  32  registered operands, shared by all units
- add_op  out  2  req_op[1:0] for the adder
- add_run, mul_run, div_run  out  1  run strobes
- add_stall, mul_stall, div_stall  in  1  unit stall
- add_z, mul_z, div_z  in  32  unit results

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_z=0; all run outputs=0; unit_x=unit_y=0; add_op=0; cycle counter=0.
- Reset mid-operation: run drops immediately and any in-flight result is discarded. Units self-clear because their state counters reset when run is low.
- States: IDLE, RUN, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, x and y.
  - Ops 0-5 go to RUN.
  - Ops 6/7 go to HOLD with rsp_z=0 and rsp_err=1. No unit is run.
- RUN:
  - Exactly one run output is high, selected by the latched op: 0-3 add_run, 4 mul_run, 5 div_run. All run outputs are registered.
  - unit_x, unit_y and add_op are stable for the whole of RUN; units read operands combinationally.
  - Each RUN cycle, sample the selected unit's stall.
  - stall=0: capture the selected unit's z into rsp_z, set rsp_err=0, go to HOLD. Run goes low on the next edge.
  - stall=1: increment the counter.
  - Counter reaches MAX_WAIT with stall still 1: rsp_z=0, rsp_err=1, go to HOLD.
- HOLD:
  - rsp_valid=1; all run outputs are 0.
  - On rsp_ready, go to IDLE and clear the counter.
  - This guarantees run is low for at least one cycle between operations. Units with non-wrapping counters (e.g. the 5-bit multiplier state) require that gap.
- Latency, with the request accepted on edge T:
  - FAD/FSB/FLR/FLT: run high for 4 cycles, rsp_valid at T+5.
  - FML: 26 run cycles, rsp_valid at T+27.
  - FDV: 27 run cycles, rsp_valid at T+28.
- Throughput: one op per (latency + 1 + response wait) cycles. No pipelining and no request queue.
- req_valid held during RUN/HOLD is ignored until IDLE (req_ready=0).
- rsp_z and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
- The controller does not interpret results. Divide-by-zero and overflow encodings from the units pass through unchanged.

Optional Feature:
- Macro: FPU_ISSUE_PERF_EN.
- Defined:
  - Adds a 32-bit output perf_busy, counting cycles spent in RUN.
  - Adds a 16-bit output perf_ops, counting completed non-error responses.
  - Both counters saturate, reset to 0 on rst_n, and are also cleared by a 1-cycle perf_clr input.
  - perf_clr takes priority over increment in the same cycle.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- FAD, x=3F800000, y=40000000, with real units, rsp_ready tied 1 -> add_run high 4 cycles, rsp_valid at T+5, rsp_z=40400000, rsp_err=0.
- FML, x=40000000, y=40400000 -> mul_run high 26 cycles, rsp_z=40C00000 at T+27; next FML accepted only after one run-low cycle; its result is again correct.
- FDV, x=3F800000, y=00000000 -> rsp_z=7F800000 at T+28; FLR x=40490FDB -> rsp_z=00000003.
- req_op=6 -> rsp_valid at T+1, rsp_z=0, rsp_err=1, no run asserted; rsp_ready held 0 for 5 cycles -> response stable, req_ready=0 throughout.
- Stub unit with stall stuck at 1, MAX_WAIT=40 -> run drops after 40 stall cycles, rsp_err=1, rsp_z=0, controller returns to IDLE after rsp_ready.
- rst_n asserted during FML run cycle 10 -> mul_run=0 and rsp_valid=0 immediately; a new FAD after reset returns 40400000 correctly.
